// File: rtl/sata_oob_pkg.sv
// Shared SATA OOB definitions: gap classes, detector states, nominal timing
// and default detection windows (also used by the OOB burst transmitter model).
package sata_oob_pkg;

  localparam int unsigned UIOOB            = 160;
  localparam int unsigned NOM_BURST        = UIOOB;
  localparam int unsigned NOM_WAKE_GAP     = 160;
  localparam int unsigned NOM_INIT_GAP     = 480;

  localparam int unsigned DEF_BURST_MIN    = 120;
  localparam int unsigned DEF_BURST_MAX    = 200;
  localparam int unsigned DEF_WAKE_GAP_MIN = 110;
  localparam int unsigned DEF_WAKE_GAP_MAX = 210;
  localparam int unsigned DEF_INIT_GAP_MIN = 400;
  localparam int unsigned DEF_INIT_GAP_MAX = 560;
  localparam int unsigned DEF_N_GAPS       = 3;

  typedef enum logic [1:0] {
    GAP_NONE = 2'd0,
    GAP_WAKE = 2'd1,
    GAP_INIT = 2'd2
  } gap_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } oob_state_e;

  // Inclusive window classification of a measured gap length
  function automatic gap_class_e classify_gap(
    input int unsigned len,
    input int unsigned wake_min,
    input int unsigned wake_max,
    input int unsigned init_min,
    input int unsigned init_max
  );
    if (len >= wake_min && len <= wake_max) return GAP_WAKE;
    if (len >= init_min && len <= init_max) return GAP_INIT;
    return GAP_NONE;
  endfunction

endpackage

// File: rtl/sata_oob_rx_detect_if.sv
// Line-side idle input and detector status outputs of the OOB receive detector.
interface sata_oob_rx_detect_if;
  import sata_oob_pkg::*;

  logic       i_rx_idle;
  logic       o_cominit_det;
  logic       o_comwake_det;
  logic       o_busy;
  gap_class_e o_gap_class;

  modport slave (
    input  i_rx_idle,
    output o_cominit_det, o_comwake_det, o_busy, o_gap_class
  );

  modport master (
    output i_rx_idle,
    input  o_cominit_det, o_comwake_det, o_busy, o_gap_class
  );

endinterface

// File: rtl/sata_oob_glitch_filter.sv
// 3-tap majority filter on the squelch input; removes single-cycle glitches
// at the cost of two cycles of edge latency.
module sata_oob_glitch_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_idle,
  output logic rx_idle_c
);

  logic [2:0] taps;

  // Reset to idle so the detector does not see a phantom burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) taps <= 3'b111;
    else        taps <= {taps[1:0], rx_idle};
  end

  assign rx_idle_c = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);

endmodule

// File: rtl/sata_oob_rx_detect.sv
// SATA OOB receive detector: measures burst/gap lengths on the squelch signal
// and pulses COMINIT or COMWAKE detect. Optional OOB_GLITCH_FILTER_EN adds a
// majority filter on the idle input.
module sata_oob_rx_detect
  import sata_oob_pkg::*;
#(
  parameter int unsigned BURST_MIN    = DEF_BURST_MIN,
  parameter int unsigned BURST_MAX    = DEF_BURST_MAX,
  parameter int unsigned WAKE_GAP_MIN = DEF_WAKE_GAP_MIN,
  parameter int unsigned WAKE_GAP_MAX = DEF_WAKE_GAP_MAX,
  parameter int unsigned INIT_GAP_MIN = DEF_INIT_GAP_MIN,
  parameter int unsigned INIT_GAP_MAX = DEF_INIT_GAP_MAX,
  parameter int unsigned N_GAPS       = DEF_N_GAPS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  sata_oob_rx_detect_if.slave   bus
);

  localparam int unsigned CW = $clog2(INIT_GAP_MAX + 2);
  localparam int unsigned SW = $clog2(N_GAPS + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(INIT_GAP_MAX + 1);
  localparam logic [SW-1:0] SEQ_FULL = SW'(N_GAPS);

  logic rx_idle_c;

`ifdef OOB_GLITCH_FILTER_EN
  sata_oob_glitch_filter u_glitch_filter (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .rx_idle   (bus.i_rx_idle),
    .rx_idle_c (rx_idle_c)
  );
`else
  assign rx_idle_c = bus.i_rx_idle;
`endif

  oob_state_e    state, state_n;
  logic [CW-1:0] count, count_n, count_inc_c;
  logic [SW-1:0] seq_cnt, seq_cnt_n;
  gap_class_e    seq_class, seq_class_n;
  gap_class_e    gap_class, gap_class_n;
  gap_class_e    cls_c;
  logic          burst_ok, burst_ok_n;
  logic          fired, fired_n;
  logic          cominit, cominit_n;
  logic          comwake, comwake_n;
  logic          busy, busy_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      seq_cnt   <= '0;
      seq_class <= GAP_NONE;
      gap_class <= GAP_NONE;
      burst_ok  <= 1'b0;
      fired     <= 1'b0;
      cominit   <= 1'b0;
      comwake   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      seq_cnt   <= seq_cnt_n;
      seq_class <= seq_class_n;
      gap_class <= gap_class_n;
      burst_ok  <= burst_ok_n;
      fired     <= fired_n;
      cominit   <= cominit_n;
      comwake   <= comwake_n;
      busy      <= busy_n;
    end
  end

  // Burst/gap measurement, sequence tracking and detect pulse generation
  always_comb begin
    state_n     = state;
    count_n     = count;
    seq_cnt_n   = seq_cnt;
    seq_class_n = seq_class;
    gap_class_n = gap_class;
    burst_ok_n  = burst_ok;
    fired_n     = fired;
    cominit_n   = 1'b0;
    comwake_n   = 1'b0;
    cls_c       = GAP_NONE;
    count_inc_c = (count == CNT_SAT) ? count : count + CW'(1);

    case (state)
      ST_IDLE: begin
        if (!rx_idle_c) begin
          state_n = ST_BURST;
          count_n = CW'(1);
        end
      end
      ST_BURST: begin
        if (!rx_idle_c) begin
          count_n = count_inc_c;
        end else begin
          state_n    = ST_GAP;
          count_n    = CW'(1);
          burst_ok_n = (count >= CW'(BURST_MIN)) && (count <= CW'(BURST_MAX));
          if (!burst_ok_n) begin
            seq_cnt_n = '0;
            fired_n   = 1'b0;
          end
        end
      end
      ST_GAP: begin
        if (rx_idle_c) begin
          if (count_inc_c == CNT_SAT) begin
            state_n     = ST_IDLE;
            count_n     = '0;
            seq_cnt_n   = '0;
            fired_n     = 1'b0;
            gap_class_n = GAP_NONE;
          end else begin
            count_n = count_inc_c;
          end
        end else begin
          cls_c       = classify_gap(32'(count), WAKE_GAP_MIN, WAKE_GAP_MAX,
                                     INIT_GAP_MIN, INIT_GAP_MAX);
          gap_class_n = cls_c;
          state_n     = ST_BURST;
          count_n     = CW'(1);
          if (burst_ok && cls_c != GAP_NONE) begin
            if (cls_c == seq_class) begin
              if (seq_cnt != SEQ_FULL) seq_cnt_n = seq_cnt + SW'(1);
            end else begin
              seq_class_n = cls_c;
              seq_cnt_n   = SW'(1);
              fired_n     = 1'b0;
            end
          end else begin
            seq_cnt_n = '0;
            fired_n   = 1'b0;
          end
          // Pulse only once per unbroken run of qualifying gaps
          if (seq_cnt_n == SEQ_FULL && !fired_n) begin
            fired_n   = 1'b1;
            cominit_n = (seq_class_n == GAP_INIT);
            comwake_n = (seq_class_n == GAP_WAKE);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  assign bus.o_cominit_det = cominit;
  assign bus.o_comwake_det = comwake;
  assign bus.o_busy        = busy;
  assign bus.o_gap_class   = gap_class;

endmodule

// File: tb/tb_sata_oob_rx_detect.sv
// Scoreboard bench for sata_oob_rx_detect: expected detect pulses are queued
// as bursts are driven and matched against the pulses the detector emits.
module tb_sata_oob_rx_detect;
  import sata_oob_pkg::*;

`ifdef OOB_GLITCH_FILTER_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int K_WAKE = 1;
  localparam int K_INIT = 2;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  int bl[$];
  int gl[$];
  int gcl[$];
  int glt_idx = -1;
  int glt_pos = 0;

  sata_oob_rx_detect_if bus ();

  sata_oob_rx_detect dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at cyc=%0d", tag, got, want, cyc);
    end
  endtask

  // Pulse monitor: every detect pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && (bus.o_cominit_det || bus.o_comwake_det)) begin
      exp_t e;
      check_eq("det_exclusive", int'(bus.o_cominit_det & bus.o_comwake_det), 0);
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", int'({bus.o_cominit_det, bus.o_comwake_det}), 0);
      end else begin
        e = sb.pop_front();
        check_eq("pulse_kind", int'({bus.o_cominit_det, bus.o_comwake_det}), e.kind);
        check_eq("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  // One burst of b cycles (optional 1-cycle glitch at glt) followed by g idle cycles
  task automatic bg(input int b, input int g, input int kind, input int gc_want, input int glt);
    exp_t e;
    if (kind != 0) begin
      e.kind = kind;
      e.cyc  = cyc + 1 + LAT;
      sb.push_back(e);
    end
    bus.i_rx_idle = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    check_eq("busy_in_burst", int'(bus.o_busy), 1);
    if (gc_want >= 0) check_eq("gap_class", int'(bus.o_gap_class), gc_want);
    if (glt > 0) begin
      repeat (glt - LAT - 1) @(negedge clk);
      bus.i_rx_idle = 1'b1;
      @(negedge clk);
      bus.i_rx_idle = 1'b0;
      repeat (b - glt - 1) @(negedge clk);
    end else begin
      repeat (b - LAT - 1) @(negedge clk);
    end
    bus.i_rx_idle = 1'b1;
    repeat (g) @(negedge clk);
  endtask

  task automatic run_seq(input int pidx, input int pkind);
    for (int i = 0; i < bl.size(); i++)
      bg(bl[i], gl[i], (i == pidx) ? pkind : 0, gcl[i], (i == glt_idx) ? glt_pos : 0);
  endtask

  task automatic end_seq(input string tag);
    bus.i_rx_idle = 1'b1;
    repeat (600) @(negedge clk);
    check_eq({tag, "_busy_end"}, int'(bus.o_busy), 0);
    check_eq({tag, "_pending"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    bus.i_rx_idle = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", int'(bus.o_busy), 0);
    check_eq("rst_cominit", int'(bus.o_cominit_det), 0);
    check_eq("rst_comwake", int'(bus.o_comwake_det), 0);
    check_eq("rst_gap_class", int'(bus.o_gap_class), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // COMINIT: 6 x (160 burst, 480 gap), then idle timeout timing
    bl = '{160, 160, 160, 160, 160, 160};
    gl = '{480, 480, 480, 480, 480, 0};
    gcl = '{0, 2, 2, 2, 2, 2};
    run_seq(3, K_INIT);
    repeat (560 + LAT) @(negedge clk);
    check_eq("busy_before_timeout", int'(bus.o_busy), 1);
    @(negedge clk);
    check_eq("busy_after_timeout", int'(bus.o_busy), 0);
    check_eq("class_after_timeout", int'(bus.o_gap_class), 0);
    end_seq("init6");

    // COMWAKE: 6 x (160, 160)
    bl = '{160, 160, 160, 160, 160, 160};
    gl = '{160, 160, 160, 160, 160, 160};
    gcl = '{0, 1, 1, 1, 1, 1};
    run_seq(3, K_WAKE);
    check_eq("wake_class_hold", int'(bus.o_gap_class), 1);
    end_seq("wake6");

    // Short third burst restarts the count
    bl = '{160, 160, 100, 160, 160, 160, 160, 160};
    gl = '{480, 480, 480, 480, 480, 480, 480, 0};
    gcl = '{0, 2, 2, 2, 2, 2, 2, 2};
    run_seq(6, K_INIT);
    end_seq("short_burst");

    // Class change init -> wake
    bl = '{160, 160, 160, 160, 160, 160};
    gl = '{480, 480, 160, 160, 160, 0};
    gcl = '{0, 2, 2, 1, 1, 1};
    run_seq(5, K_WAKE);
    end_seq("init_to_wake");

    // Class-none gap inside a wake run
    bl = '{160, 160, 160, 160, 160, 160, 160};
    gl = '{160, 160, 300, 160, 160, 160, 0};
    gcl = '{0, 1, 1, 0, 1, 1, 1};
    run_seq(6, K_WAKE);
    end_seq("none_gap");

    // Inclusive wake gap and burst boundaries
    bl = '{120, 200, 120, 200};
    gl = '{110, 210, 110, 0};
    gcl = '{0, 1, 1, 1};
    run_seq(3, K_WAKE);
    end_seq("wake_edges");

    // Inclusive init gap boundaries
    bl = '{160, 160, 160, 160};
    gl = '{400, 560, 400, 0};
    gcl = '{0, 2, 2, 2};
    run_seq(3, K_INIT);
    end_seq("init_edges");

    // 561-cycle gap times out; detection needs four fresh bursts
    bl = '{160, 160, 160, 160, 160};
    gl = '{561, 480, 480, 480, 0};
    gcl = '{0, 0, 2, 2, 2};
    run_seq(4, K_INIT);
    end_seq("gap_561");

    // Over-long burst breaks the run
    bl = '{160, 201, 160, 160, 160, 160};
    gl = '{160, 160, 160, 160, 160, 0};
    gcl = '{0, 1, 1, 1, 1, 1};
    run_seq(5, K_WAKE);
    end_seq("long_burst");

    // Reset mid-gap after two valid gaps
    bl = '{160, 160, 160};
    gl = '{480, 480, 200};
    gcl = '{0, 2, 2};
    run_seq(-1, 0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", int'(bus.o_busy), 0);
    check_eq("midrst_gap_class", int'(bus.o_gap_class), 0);
    check_eq("midrst_cominit", int'(bus.o_cominit_det), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bl = '{160, 160, 160, 160};
    gl = '{480, 480, 480, 0};
    gcl = '{0, 2, 2, 2};
    run_seq(3, K_INIT);
    end_seq("after_reset");

`ifdef OOB_GLITCH_FILTER_EN
    // Single-cycle idle glitch inside burst 2 is filtered out
    bl = '{160, 160, 160, 160};
    gl = '{160, 160, 160, 0};
    gcl = '{0, 1, 1, 1};
    glt_idx = 1;
    glt_pos = 80;
    run_seq(3, K_WAKE);
    glt_idx = -1;
    end_seq("glitch");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
